// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - opcodes, FSM states and instruction field positions for regfile_ctrl
package regfile_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_ADDI = 3'b011,
    OP_MOV  = 3'b100,
    OP_LI   = 3'b101,
    OP_LW   = 3'b110,
    OP_SW   = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_e;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int RD_BIT  = 4;
  localparam int RS_BIT  = 3;
  localparam int IMM_MSB = 2;
  localparam int IMM_W   = IMM_MSB + 1;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/regfile_ctrl_alu.sv
// rtl/regfile_ctrl_alu.sv - combinational add/sub/pass-rs/pass-imm selected by opcode
module regfile_ctrl_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] imm_ext;

  assign imm_ext = DATA_W'(imm);

  // Carries and borrows fall off the top; results are modulo 2^DATA_W.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_ADDI: y = a + imm_ext;
      OP_MOV:  y = b;
      OP_LI:   y = imm_ext;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - issue/writeback FSM for register_file; REGFILE_CTRL_TIMEOUT_EN adds memory timeout
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  output logic              instr_ready,
  output logic              rd,
  output logic              rs,
  output logic              regSelect,
  output logic              immSelect,
  output logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] rs_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

  if (DATA_W != 8 || MEM_TIMEOUT < 1) begin : g_cfg_check
    $error("regfile_ctrl: DATA_W must be 8 and MEM_TIMEOUT at least 1");
  end

  state_e            state_q, state_d;
  opcode_e           op_q;
  logic              rd_q, rs_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] a_q, b_q, result_q, alu_y;
  logic              accept, retire, done_q, tmo_hit;

  assign accept = (state_q == ST_IDLE) && instr_valid;
  assign done   = done_q;

  regfile_ctrl_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .imm (imm_q),
    .y   (alu_y)
  );

`ifdef REGFILE_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;

  // Leaving MEM clears the count, so every MEM visit starts from zero.
  assign tmo_hit = (state_q == ST_MEM) && !mem_ack && (tmo_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign err     = err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == ST_MEM) ? tmo_cnt_q + 1'b1 : '0;
      err_q     <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    instr_ready = 1'b0;
    rd          = 1'b0;
    rs          = 1'b0;
    regSelect   = 1'b0;
    immSelect   = 1'b0;
    imm         = '0;
    write_data  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = !RST;
        if (instr_valid) state_d = ST_READ;
      end
      ST_READ: begin
        rd = rd_q;
        rs = rs_q;
        if (op_q == OP_LI) begin
          immSelect = 1'b1;
          imm       = imm_q;
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_mem_op(op_q)) begin
          state_d = ST_MEM;
        end else if (op_q == OP_NOP) begin
          state_d = ST_IDLE;
          retire  = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req   = !RST;
        mem_we    = !RST && (op_q == OP_SW);
        mem_addr  = b_q;
        mem_wdata = a_q;
        if (mem_ack) begin
          if (op_q == OP_LW) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
            retire  = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        // A reset landing on the write-back cycle must not reach the register file.
        regSelect  = !RST;
        rd         = rd_q;
        write_data = result_q;
        state_d    = ST_IDLE;
        retire     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      op_q     <= OP_NOP;
      rd_q     <= 1'b0;
      rs_q     <= 1'b0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= retire;
      if (accept) begin
        op_q  <= opcode_e'(instr[OP_MSB:OP_LSB]);
        rd_q  <= instr[RD_BIT];
        rs_q  <= instr[RS_BIT];
        imm_q <= instr[IMM_MSB:0];
      end
      if (state_q == ST_READ) begin
        a_q <= rd_data;
        b_q <= rs_data;
      end
      if (state_q == ST_EXEC) result_q <= alu_y;
      if (state_q == ST_MEM && mem_ack && op_q == OP_LW) result_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - randomized self-checking bench for regfile_ctrl against a behavioural model
module tb_regfile_ctrl;

  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = '0;
  logic       instr_ready, rd, rs, regSelect, immSelect;
  logic [2:0] imm;
  logic [7:0] write_data, rd_data, rs_data;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       mem_ack = 1'b0;
  logic       done, err;

  logic [7:0] rf     [2];
  logic [7:0] exp_rf [2];
  logic [7:0] mem    [256];
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 CLK = ~CLK;

  assign rd_data = immSelect ? {5'b0, imm} : rf[rd];
  assign rs_data = rf[rs];

  regfile_ctrl dut (
    .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rd(rd), .rs(rs), .regSelect(regSelect), .immSelect(immSelect), .imm(imm),
    .write_data(write_data), .rd_data(rd_data), .rs_data(rs_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_rf(input logic [7:0] v0, input logic [7:0] v1);
    rf[0] = v0; rf[1] = v1; exp_rf[0] = v0; exp_rf[1] = v1;
  endtask

  // Issue one instruction (called at a negedge with the DUT idle); lat < 0 means memory never acks.
  task automatic run_instr(input logic [7:0] ins, input int lat);
    logic [2:0] op;
    logic       d, s, mwe, wr_rd, rd1, rs1, ready_end;
    logic [2:0] im, imm_val;
    logic [7:0] a, b, r, wd, maddr, mwd;
    bit         is_mem, abort, exp_write;
    int         exp_done, exp_wb, exp_err, exp_mem_n;
    int         wr_cnt, wb_cyc, done_cyc, err_cyc, mem_n, mem_first, imm_cnt, imm_cyc, busy_rdy;

    op = ins[7:5]; d = ins[4]; s = ins[3]; im = ins[2:0];
    a = exp_rf[d]; b = exp_rf[s];
    is_mem = (op >= 3'd6);
    abort  = (lat < 0);
    exp_write = !abort && (op != 3'd0) && (op != 3'd7);
    case (op)
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a + {5'b0, im};
      3'd4: r = b;
      3'd5: r = {5'b0, im};
      3'd6: r = mem[b];
      default: r = 8'h00;
    endcase
    exp_mem_n = !is_mem ? 0 : (abort ? TMO : lat + 1);
    exp_wb    = is_mem ? 4 + lat : 3;
    exp_done  = abort ? -1 : (exp_write ? exp_wb + 1 : exp_wb);
    exp_err   = abort ? 3 + TMO : -1;

    wr_cnt = 0; wb_cyc = -1; done_cyc = -1; err_cyc = -1; mem_n = 0; mem_first = -1;
    imm_cnt = 0; imm_cyc = -1; busy_rdy = 0; imm_val = '0; wd = '0; wr_rd = 1'b0;
    maddr = '0; mwd = '0; mwe = 1'b0; rd1 = 1'b0; rs1 = 1'b0; ready_end = 1'b0;

    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1; instr = ins;
    @(posedge CLK);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge CLK);
      if (instr_ready && !done && !err) busy_rdy++;
      if (cyc == 1) begin rd1 = rd; rs1 = rs; end
      if (immSelect) begin imm_cnt++; imm_val = imm; imm_cyc = cyc; end
      if (regSelect) begin wr_cnt++; wb_cyc = cyc; wd = write_data; wr_rd = rd; end
      if (err) err_cyc = cyc;
      if (done) done_cyc = cyc;
      if (mem_req) begin
        if (mem_n == 0) mem_first = cyc;
        maddr = mem_addr; mwe = mem_we; mwd = mem_wdata;
        mem_ack = (mem_n == lat);
        mem_rdata = mem[mem_addr];
        mem_n++;
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = 8'($urandom);
      end
      if (done || err) begin ready_end = instr_ready; break; end
      instr_valid = 1'($urandom_range(0, 1));
      instr = 8'($urandom);
    end
    instr_valid = 1'b0; mem_ack = 1'b0;

    chk("wr_cnt", wr_cnt, exp_write ? 1 : 0);
    if (exp_write) begin
      chk("wb_cyc", wb_cyc, exp_wb);
      chk("write_data", wd, r);
      chk("wr_rd", wr_rd, d);
    end
    chk("done_cyc", done_cyc, exp_done);
    chk("err_cyc", err_cyc, exp_err);
    chk("ready_end", ready_end, 1);
    chk("busy_ready", busy_rdy, 0);
    chk("read_rd", rd1, d);
    chk("read_rs", rs1, s);
    chk("mem_cycles", mem_n, exp_mem_n);
    if (is_mem) begin
      chk("mem_first", mem_first, 3);
      chk("mem_addr", maddr, b);
      chk("mem_we", mwe, op == 3'd7);
      if (op == 3'd7) chk("mem_wdata", mwd, a);
    end
    chk("imm_sel", imm_cnt, op == 3'd5 ? 1 : 0);
    if (op == 3'd5) begin
      chk("imm_val", imm_val, im);
      chk("imm_cyc", imm_cyc, 1);
    end

    if (wr_cnt > 0) rf[wr_rd] = wd;
    if (exp_write) exp_rf[d] = r;
    if (op == 3'd7 && !abort) mem[b] = a;
    chk("rf0", rf[0], exp_rf[0]);
    chk("rf1", rf[1], exp_rf[1]);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    set_rf(8'h00, 8'h00);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset_ctl", {rd, rs, regSelect, immSelect, imm, mem_req, mem_we, done, err}, 0);
    chk("reset_data", {write_data, mem_addr, mem_wdata}, 0);
    chk("reset_ready", instr_ready, 1);

    set_rf(8'd7, 8'd3);
    run_instr(8'b001_0_1_000, 0);
    set_rf(8'd3, 8'd7);
    run_instr(8'b010_0_1_000, 0);
    run_instr(8'b101_1_0_100, 0);
    set_rf(8'h00, 8'h20);
    mem[8'h20] = 8'h5A;
    run_instr(8'b110_0_1_000, 4);
    set_rf(8'h30, 8'h11);
    run_instr(8'b111_1_0_000, 2);
    run_instr(8'b000_0_0_000, 0);
`ifdef REGFILE_CTRL_TIMEOUT_EN
    run_instr(8'b110_0_1_000, -1);
`else
    run_instr(8'b110_0_1_000, 30);
`endif

    // Reset landing on the WB cycle of an ADD.
    set_rf(8'd7, 8'd3);
    instr_valid = 1'b1; instr = 8'b001_0_1_000;
    @(posedge CLK);
    @(negedge CLK); instr_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pre_wb", regSelect, 1);
    RST = 1'b1;
    #1 chk("rst_wb_gate", regSelect, 0);
    @(negedge CLK);
    chk("rst_ctl", {rd, rs, regSelect, immSelect, imm, mem_req, mem_we, done, err}, 0);
    chk("rst_data", {write_data, mem_addr, mem_wdata}, 0);
    RST = 1'b0;
    #1 chk("rst_ready", instr_ready, 1);
    @(negedge CLK);
    chk("rst_no_done", {done, regSelect}, 0);

    for (int n = 0; n < 40; n++) run_instr(8'($urandom), $urandom_range(0, 5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
